// File: rtl/pipe_reg_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse; DEPTH cycles from
// input presentation to o_valid when empty, 1 beat/cycle streaming; full+stalled asserts no o_ready.
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_ready,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg_chain: DEPTH must be >= 1");
  end

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] can_load;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  // A stage can take a beat if it is empty or everything downstream of it moves.
  always_comb begin
    logic chain;
    chain = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain       = !v_q[k] || chain;
      can_load[k] = chain;
    end
  end

  assign o_ready = can_load[0] && !i_flush;
  assign o_valid = v_q[DEPTH-1];
  assign o_data  = d_q[DEPTH-1];

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < DEPTH; k++) begin
      d_d[k] = d_q[k];
    end
    if (i_flush) begin
      v_d = '0;
    end else begin
      if (can_load[0]) begin
        v_d[0] = i_valid;
        if (i_valid) begin
          d_d[0] = i_data;
        end
      end
      // An empty beat moving in clears valid but keeps the old data word.
      for (int k = 1; k < DEPTH; k++) begin
        if (can_load[k]) begin
          v_d[k] = v_q[k-1];
          if (v_q[k-1]) begin
            d_d[k] = d_q[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  always_comb begin
    o_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      o_count = o_count + CW'(v_q[k]);
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Bench for pipe_reg_chain: directed DEPTH=3 scenarios, then random traffic on
// WIDTH=16 chains of DEPTH 1, 2 and 5 against queue-based models.
module tb_pipe_reg_chain;

  logic       clk;
  logic       rst;
  logic       fl;
  logic       vld;
  logic [7:0] dat;
  logic       rdy;
  logic       o_rdy;
  logic       o_vld;
  logic [7:0] o_dat;
  logic [1:0] o_cnt;

  logic        rv;
  logic        rr;
  logic        rf;
  logic [15:0] rd;
  logic        rnd_on;
  logic        fin_chk;

  int n_chk;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  pipe_reg_chain #(.WIDTH(8), .DEPTH(3)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_flush (fl),
    .i_valid (vld),
    .i_data  (dat),
    .o_ready (o_rdy),
    .o_valid (o_vld),
    .o_data  (o_dat),
    .i_ready (rdy),
    .o_count (o_cnt)
  );

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 5);
    logic                     r_o_rdy;
    logic                     r_o_vld;
    logic [15:0]              r_o_dat;
    logic [$clog2(D+1)-1:0]   r_o_cnt;
    logic [15:0]              q[$];
    logic                     held;
    logic [15:0]              held_dat;
    logic                     exp_rdy;

    pipe_reg_chain #(.WIDTH(16), .DEPTH(D)) u_dut (
      .i_clk   (clk),
      .i_reset (rst),
      .i_flush (rf),
      .i_valid (rv),
      .i_data  (rd),
      .o_ready (r_o_rdy),
      .o_valid (r_o_vld),
      .o_data  (r_o_dat),
      .i_ready (rr),
      .o_count (r_o_cnt)
    );

    initial held = 1'b0;

    always @(negedge clk) begin
      if (rnd_on) begin
        exp_rdy = !rf && ((q.size() < D) || rr);
        check($sformatf("d%0d_rdy", D), 32'(r_o_rdy), 32'(exp_rdy));
        check($sformatf("d%0d_cnt", D), 32'(r_o_cnt), 32'(q.size()));
        if (q.size() == D) check($sformatf("d%0d_fullvld", D), 32'(r_o_vld), 32'd1);
        if (q.size() == 0) check($sformatf("d%0d_emptyvld", D), 32'(r_o_vld), 32'd0);
        else if (r_o_vld) check($sformatf("d%0d_dat", D), 32'(r_o_dat), 32'(q[0]));
        if (held && r_o_vld) check($sformatf("d%0d_hold", D), 32'(r_o_dat), 32'(held_dat));
        held     = r_o_vld && !rr && !rf;
        held_dat = r_o_dat;
        if (rf) begin
          q.delete();
        end else begin
          if (r_o_vld && rr && q.size() > 0) void'(q.pop_front());
          if (rv && exp_rdy) q.push_back(rd);
        end
      end
      if (fin_chk) begin
        check($sformatf("d%0d_drain", D), 32'(q.size()), 32'd0);
        check($sformatf("d%0d_endcnt", D), 32'(r_o_cnt), 32'd0);
      end
    end
  end

  initial begin
    logic [7:0] got[$];
    int idx;
    int vb;
    int rb;
    n_chk = 0; n_err = 0;
    rst = 1'b1; fl = 1'b0; vld = 1'b1; dat = 8'h5A; rdy = 1'b0;
    rv = 1'b0; rr = 1'b0; rf = 1'b0; rd = '0; rnd_on = 1'b0; fin_chk = 1'b0;

    // Reset held two cycles with a beat offered
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; vld = 1'b0;
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_dat", 32'(o_dat), 32'd0);
    check("rst_cnt", 32'(o_cnt), 32'd0);
    @(negedge clk);
    check("rst_rdy", 32'(o_rdy), 32'd1);
    tick();

    // Streaming 0x01..0x10 with i_ready held high
    rdy = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      vld = (n <= 16);
      dat = 8'(n);
      tick();
      check("str_vld", 32'(o_vld), 32'((n >= 3) && (n <= 18)));
      if (n >= 3 && n <= 18) check("str_dat", 32'(o_dat), 32'(n - 2));
      if (n >= 3 && n <= 16) check("str_cnt", 32'(o_cnt), 32'd3);
    end
    vld = 1'b0;

    // Backpressure: four beats offered, only three fit
    rdy = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      vld = 1'b1;
      dat = 8'h31 + 8'(idx);
      @(negedge clk);
      if (o_rdy) idx++;
      tick();
    end
    check("bp_acc", 32'(idx), 32'd3);
    check("bp_cnt", 32'(o_cnt), 32'd3);
    check("bp_vld", 32'(o_vld), 32'd1);
    check("bp_dat", 32'(o_dat), 32'h31);
    @(negedge clk);
    check("bp_rdy", 32'(o_rdy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_hold", 32'(o_dat), 32'h31);
    end
    rdy = 1'b1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      vld = (idx < 4);
      dat = 8'h31 + 8'(idx);
      @(negedge clk);
      if (vld && o_rdy) idx++;
      if (o_vld) got.push_back(o_dat);
      tick();
    end
    vld = 1'b0;
    check("bp_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check("bp_ord", 32'(got[i]), 32'h31 + 32'(i));
    end

    // Bubble collapse: A, two idle cycles, B, output stalled
    rdy = 1'b0;
    vld = 1'b1; dat = 8'hA1; tick();
    vld = 1'b0; tick(); tick();
    vld = 1'b1; dat = 8'hB2; tick();
    vld = 1'b0; tick(); tick();
    check("bub_cnt", 32'(o_cnt), 32'd2);
    check("bub_vld", 32'(o_vld), 32'd1);
    check("bub_dat", 32'(o_dat), 32'hA1);
    @(negedge clk);
    check("bub_rdy", 32'(o_rdy), 32'd1);
    tick();
    rdy = 1'b1;
    check("bub_a", 32'(o_dat), 32'hA1);
    tick();
    check("bub_bvld", 32'(o_vld), 32'd1);
    check("bub_b", 32'(o_dat), 32'hB2);
    tick();
    check("bub_empty", 32'(o_vld), 32'd0);

    // Flush a full chain while 0xAA is offered
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; dat = 8'h51 + 8'(i); tick();
    end
    check("fl_full", 32'(o_cnt), 32'd3);
    fl = 1'b1; vld = 1'b1; dat = 8'hAA;
    @(negedge clk);
    check("fl_rdy", 32'(o_rdy), 32'd0);
    check("fl_shown", 32'(o_vld), 32'd1);
    tick();
    fl = 1'b0; vld = 1'b0;
    check("fl_cnt", 32'(o_cnt), 32'd0);
    check("fl_vld", 32'(o_vld), 32'd0);
    rdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("fl_none", 32'(o_vld), 32'd0);
    end

    // Mid-operation reset drops held beats
    rdy = 1'b0;
    vld = 1'b1; dat = 8'h61; tick();
    dat = 8'h62; tick();
    vld = 1'b0;
    check("mr_pre", 32'(o_cnt), 32'd2);
    rst = 1'b1; tick();
    rst = 1'b0;
    check("mr_cnt", 32'(o_cnt), 32'd0);
    check("mr_vld", 32'(o_vld), 32'd0);
    check("mr_dat", 32'(o_dat), 32'd0);

    // Random traffic on the WIDTH=16 chains
    rnd_on = 1'b1;
    vb = 2; rb = 2;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (cyc % 500 == 0) begin
        vb = $urandom_range(1, 4);
        rb = $urandom_range(1, 4);
      end
      rv = ($urandom_range(0, 3) < vb);
      rr = ($urandom_range(0, 3) < rb);
      rf = ($urandom_range(0, 63) == 0);
      rd = 16'($urandom);
      tick();
    end
    rv = 1'b0; rf = 1'b0; rr = 1'b1;
    repeat (12) tick();
    rnd_on = 1'b0;
    fin_chk = 1'b1;
    @(negedge clk);
    #1;
    fin_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
